// File: rtl/input_pkg.sv
// Shared definitions for the decimal input entities: FSM states, digit limits
// and the BCD nibble type.
package input_pkg;

   localparam int N_DIGITOS_PADRAO = 8;
   localparam logic [3:0] DIGITO_MAX = 4'd9;

   typedef logic [3:0] nibble_t;

   typedef enum logic [1:0] {
      OCIOSO,
      ENTRADA,
      CONVERTE,
      PRONTO
   } estado_t;

endpackage

// File: rtl/mult10_soma.sv
// One Horner step of decimal-to-binary conversion: acc*10 + nibble,
// built from shifts and adds only.
module mult10_soma
   import input_pkg::*;
(
   input  logic [31:0] acc,
   input  nibble_t     nibble,
   output logic [31:0] resultado
);

   assign resultado = (acc << 3) + (acc << 1) + {28'd0, nibble};

endmodule

// File: rtl/input_bcd_binario.sv
// Collects up to N_DIGITOS decimal digits, echoes them as packed BCD and,
// on confirmation, converts them to a 32-bit binary value for the datapath.
module input_bcd_binario
   import input_pkg::*;
#(
   parameter int N_DIGITOS = N_DIGITOS_PADRAO
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   requisicao,
   input  logic [3:0]             digito,
   input  logic                   insere,
   input  logic                   confirma,
   input  logic                   limpa,
   output logic [4*N_DIGITOS-1:0] bcd_atual,
   output logic [3:0]             n_digitos,
   output logic [31:0]            binario,
   output logic                   pronto,
   output logic                   ocupado,
   output logic                   erro
);

   localparam logic [3:0] N_MAX   = 4'(N_DIGITOS);
   localparam logic [3:0] IDX_INI = 4'(N_DIGITOS - 1);

   estado_t estado, estado_prox;

   logic [31:0]            acc;
   logic [3:0]             idx;
   logic [31:0]            soma;
   nibble_t                nibble_sel;
   logic [4*N_DIGITOS-1:0] bcd_desloc;
   logic                   em_entrada;
   logic                   aceita;
   logic                   rejeita;

   always_ff @(posedge clock) begin
      if (reset) estado <= OCIOSO;
      else       estado <= estado_prox;
   end

   // Dropping requisicao aborts entry or conversion; limpa beats confirma beats insere.
   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:   if (requisicao) estado_prox = ENTRADA;
         ENTRADA: begin
            if (!requisicao)   estado_prox = OCIOSO;
            else if (limpa)    estado_prox = ENTRADA;
            else if (confirma) estado_prox = CONVERTE;
         end
         CONVERTE: begin
            if (!requisicao)      estado_prox = OCIOSO;
            else if (idx == 4'd0) estado_prox = PRONTO;
         end
         PRONTO:   if (!requisicao) estado_prox = OCIOSO;
         default:  estado_prox = OCIOSO;
      endcase
   end

   always_comb begin
      em_entrada = (estado == ENTRADA) && requisicao && !limpa && !confirma && insere;
      aceita     = em_entrada && (digito <= DIGITO_MAX) && (n_digitos < N_MAX);
      rejeita    = em_entrada && !aceita;
      bcd_desloc = bcd_atual << 4;
      bcd_desloc[3:0] = digito;
      nibble_sel = nibble_t'(bcd_atual >> {idx, 2'b00});
   end

   mult10_soma u_mult10_soma (
      .acc       (acc),
      .nibble    (nibble_sel),
      .resultado (soma)
   );

   // Leading unused nibbles are zero, so the conversion always walks every slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         bcd_atual <= '0;
         n_digitos <= 4'd0;
         binario   <= 32'd0;
         acc       <= 32'd0;
         idx       <= 4'd0;
         pronto    <= 1'b0;
         ocupado   <= 1'b0;
         erro      <= 1'b0;
      end else begin
         erro    <= rejeita;
         pronto  <= (estado_prox == PRONTO);
         ocupado <= (estado_prox == ENTRADA) || (estado_prox == CONVERTE);
         case (estado)
            OCIOSO: begin
               if (requisicao) begin
                  bcd_atual <= '0;
                  n_digitos <= 4'd0;
               end
            end
            ENTRADA: begin
               if (requisicao) begin
                  if (limpa) begin
                     bcd_atual <= '0;
                     n_digitos <= 4'd0;
                  end else if (confirma) begin
                     acc <= 32'd0;
                     idx <= IDX_INI;
                  end else if (aceita) begin
                     bcd_atual <= bcd_desloc;
                     n_digitos <= n_digitos + 4'd1;
                  end
               end
            end
            CONVERTE: begin
               if (requisicao) begin
                  acc <= soma;
                  idx <= idx - 4'd1;
                  if (idx == 4'd0) binario <= soma;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_input_bcd_binario.sv
// Directed checks of digit entry, conversion latency, handshake, abort and reset.
module tb_input_bcd_binario;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        requisicao = 1'b0;
   logic [3:0]  digito = 4'd0;
   logic        insere = 1'b0;
   logic        confirma = 1'b0;
   logic        limpa = 1'b0;
   logic [31:0] bcd_atual;
   logic [3:0]  n_digitos;
   logic [31:0] binario;
   logic        pronto;
   logic        ocupado;
   logic        erro;

   int errors = 0;
   int checks = 0;

   input_bcd_binario #(.N_DIGITOS(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .requisicao (requisicao),
      .digito     (digito),
      .insere     (insere),
      .confirma   (confirma),
      .limpa      (limpa),
      .bcd_atual  (bcd_atual),
      .n_digitos  (n_digitos),
      .binario    (binario),
      .pronto     (pronto),
      .ocupado    (ocupado),
      .erro       (erro)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_digit(input logic [3:0] d);
      digito = d;
      insere = 1'b1;
      tick();
      insere = 1'b0;
   endtask

   task automatic apply_confirma();
      confirma = 1'b1;
      tick();
      confirma = 1'b0;
   endtask

   // Confirm, then verify pronto stays low for 7 edges and rises on the 8th.
   task automatic convert_and_check(input string tag, input logic [31:0] exp);
      apply_confirma();
      for (int i = 0; i < 7; i++) begin
         tick();
         check_output({tag, "_pronto_early"}, {31'd0, pronto}, 32'd0);
      end
      tick();
      check_output({tag, "_pronto"}, {31'd0, pronto}, 32'd1);
      check_output({tag, "_binario"}, binario, exp);
      check_output({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
   endtask

   task automatic release_request();
      requisicao = 1'b0;
      tick();
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check_output("reset_bcd", bcd_atual, 32'd0);
      check_output("reset_n", {28'd0, n_digitos}, 32'd0);
      check_output("reset_binario", binario, 32'd0);
      check_output("reset_flags", {29'd0, pronto, ocupado, erro}, 32'd0);

      // Inputs are ignored while idle
      apply_digit(4'd5);
      check_output("idle_ignore", {27'd0, erro, n_digitos}, 32'd0);

      // Basic entry 1,2,3
      requisicao = 1'b1;
      tick();
      check_output("basic_ocupado", {31'd0, ocupado}, 32'd1);
      apply_digit(4'd1);
      apply_digit(4'd2);
      apply_digit(4'd3);
      check_output("basic_bcd", bcd_atual, 32'h0000_0123);
      check_output("basic_n", {28'd0, n_digitos}, 32'd3);
      convert_and_check("basic", 32'd123);
      release_request();
      check_output("basic_drop_pronto", {31'd0, pronto}, 32'd0);
      check_output("basic_hold_binario", binario, 32'd123);

      // Full buffer and overflow rejection
      requisicao = 1'b1;
      tick();
      check_output("full_cleared", bcd_atual, 32'd0);
      for (int i = 0; i < 8; i++) apply_digit(4'd9);
      check_output("full_bcd", bcd_atual, 32'h9999_9999);
      apply_digit(4'd9);
      check_output("full_erro", {31'd0, erro}, 32'd1);
      check_output("full_n", {28'd0, n_digitos}, 32'd8);
      tick();
      check_output("full_erro_pulse", {31'd0, erro}, 32'd0);
      convert_and_check("full", 32'h05F5_E0FF);
      release_request();

      // Invalid digit, then clear
      requisicao = 1'b1;
      tick();
      apply_digit(4'hA);
      check_output("inval_erro", {31'd0, erro}, 32'd1);
      check_output("inval_n", {28'd0, n_digitos}, 32'd0);
      apply_digit(4'd4);
      check_output("valid_no_erro", {31'd0, erro}, 32'd0);
      apply_digit(4'd5);
      check_output("pre_clear_bcd", bcd_atual, 32'h0000_0045);
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      check_output("clear_n", {28'd0, n_digitos}, 32'd0);
      check_output("clear_bcd", bcd_atual, 32'd0);
      apply_digit(4'd7);
      convert_and_check("clear", 32'd7);
      release_request();

      // Empty confirm
      requisicao = 1'b1;
      tick();
      convert_and_check("empty", 32'd0);
      release_request();
      check_output("empty_drop", {30'd0, pronto, ocupado}, 32'd0);

      // Restore binario=123, then abort a new conversion at its third cycle
      requisicao = 1'b1;
      tick();
      apply_digit(4'd1);
      apply_digit(4'd2);
      apply_digit(4'd3);
      convert_and_check("pre_abort", 32'd123);
      release_request();
      requisicao = 1'b1;
      tick();
      apply_digit(4'd8);
      apply_confirma();
      tick();
      tick();
      release_request();
      check_output("abort_flags", {30'd0, pronto, ocupado}, 32'd0);
      check_output("abort_binario", binario, 32'd123);
      for (int i = 0; i < 10; i++) tick();
      check_output("abort_late_binario", binario, 32'd123);

      // Abort wins over a simultaneous confirma
      requisicao = 1'b1;
      tick();
      apply_digit(4'd6);
      requisicao = 1'b0;
      confirma = 1'b1;
      tick();
      confirma = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check_output("abort_confirma", {binario[30:0], pronto}, {31'd123, 1'b0});

      // Reset in the middle of a conversion
      requisicao = 1'b1;
      tick();
      apply_digit(4'd5);
      apply_confirma();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_output("rst_mid_binario", binario, 32'd0);
      check_output("rst_mid_bcd", bcd_atual, 32'd0);
      check_output("rst_mid_flags", {25'd0, n_digitos, pronto, ocupado, erro}, 32'd0);
      reset = 1'b0;
      tick();
      apply_digit(4'd4);
      apply_digit(4'd2);
      convert_and_check("post_rst", 32'd42);
      release_request();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
